// File: rtl/sdiv_seq_if.sv
// ---------------------------------------------------------------------------
// sdiv_seq_if
//
// Purpose: bundles the operand and result handshakes of the sequential
// signed divider so that the divider can sit behind datapath control logic
// as one port.
//
// Parameters:
//   W          operand/result width in bits (two's complement)
//
// Signals:
//   in_valid   requester -> divider   operands valid
//   in_ready   divider   -> requester divider can accept operands
//   dividend   requester -> divider   signed dividend, W bits
//   divisor    requester -> divider   signed divisor, W bits
//   out_valid  divider   -> requester result valid
//   out_ready  requester -> divider   requester accepts result
//   quotient   divider   -> requester signed quotient, W bits
//   remainder  divider   -> requester signed remainder, W bits
//   err        divider   -> requester divide-by-zero or MIN/-1 flag
//                                     (only when SDIV_ERR_FLAG_EN is defined)
//
// Modports:
//   master     the requester side
//   slave      the divider side
//
// Build option: define SDIV_ERR_FLAG_EN to add the err signal.
// ---------------------------------------------------------------------------
interface sdiv_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

`ifdef SDIV_ERR_FLAG_EN
    logic         err;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  err
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output err
    );
`else
    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder
    );
`endif
endinterface

// File: rtl/sdiv_seq.sv
// ---------------------------------------------------------------------------
// sdiv_seq
//
// Purpose: parametrised sequential signed integer divider. Operands are
// converted to magnitudes when accepted, divided one quotient bit per clock
// with a radix-2 restoring algorithm, and the signs are applied in a final
// fix-up cycle. The quotient truncates toward zero and the remainder takes
// the sign of the dividend.
//
// Parameters:
//   W      operand/result width, 2..32
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   bus    sdiv_seq_if slave modport:
//            in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//            dividend/divisor     signed operands
//            out_valid/out_ready  result handshake
//            quotient/remainder   signed results, held until the next fix-up
//            err                  dbz | ovf (only with SDIV_ERR_FLAG_EN)
//
// Timing: counting the accepting cycle as the first, one IDLE cycle, W CALC
// cycles and one FIX cycle pass before out_valid is seen, so out_valid rises
// on the (W+2)-th rising edge counted from the accepting edge inclusive. With
// out_ready held high a new division can start every W+3 cycles.
//
// Special results:
//   divisor == 0        quotient = -1, remainder = dividend
//   MIN / -1            quotient = MIN, remainder = 0 (natural wrap)
//
// Build option: define SDIV_ERR_FLAG_EN to add the err output and the
// overflow flag register. Results are identical in both builds.
// ---------------------------------------------------------------------------
module sdiv_seq #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    sdiv_seq_if.slave bus
);

    localparam int            CW        = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [W-1:0]  ONE       = W'(1);
`ifdef SDIV_ERR_FLAG_EN
    localparam logic [W-1:0]  MIN_VAL   = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Dividend magnitude, shifted left once per CALC cycle so its MSB is
    // always the next bit to bring into the partial remainder.
    logic [W-1:0]  a_q, a_d;
    // Divisor magnitude; it stays untouched, so a zero here in FIX means the
    // operation was a divide-by-zero and no separate flag is needed.
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    pr_q, pr_d;
    logic [W-1:0]  qm_q, qm_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
`ifdef SDIV_ERR_FLAG_EN
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
`endif

    logic [W-1:0]  dividend_mag;
    logic [W-1:0]  divisor_mag;
    logic [W+1:0]  trial;
    logic          trial_ok;

    // Magnitudes of the incoming operands. |MIN| = 2^(W-1) still fits in W
    // unsigned bits, so the two's complement negation needs no extra bit.
    assign dividend_mag = bus.dividend[W-1] ? (~bus.dividend + ONE) : bus.dividend;
    assign divisor_mag  = bus.divisor[W-1]  ? (~bus.divisor  + ONE) : bus.divisor;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and trial-subtract the divisor. The partial remainder never reaches
    // 2^W, so a W+2 bit difference has a reliable sign bit.
    assign trial    = {pr_q, a_q[W-1]} - {2'b00, b_q};
    assign trial_ok = ~trial[W+1];

    // Next-state and datapath logic for all four states. Handshake outputs
    // are derived from the next state so they are registered alongside it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        pr_d      = pr_q;
        qm_d      = qm_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
`ifdef SDIV_ERR_FLAG_EN
        ovf_d     = ovf_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d       = dividend_mag;
                    b_d       = divisor_mag;
                    pr_d      = '0;
                    qm_d      = '0;
                    cnt_d     = '0;
                    neg_quo_d = bus.dividend[W-1] ^ bus.divisor[W-1];
                    neg_rem_d = bus.dividend[W-1];
`ifdef SDIV_ERR_FLAG_EN
                    ovf_d     = (bus.dividend == MIN_VAL) && (bus.divisor == '1);
`endif
                    state_d   = CALC;
                end
            end

            CALC: begin
                a_d   = {a_q[W-2:0], 1'b0};
                pr_d  = trial_ok ? trial[W:0] : {pr_q[W-1:0], a_q[W-1]};
                qm_d  = {qm_q[W-2:0], trial_ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quo_d = neg_quo_q ? (~qm_q + ONE) : qm_q;
                // With a zero divisor every trial succeeds, so the partial
                // remainder ends up holding |dividend| and sign correction
                // rebuilds the original dividend; only the quotient needs
                // forcing to -1.
                rem_d = neg_rem_q ? (~pr_q[W-1:0] + ONE) : pr_q[W-1:0];
                if (b_q == '0) begin
                    quo_d = '1;
                end
`ifdef SDIV_ERR_FLAG_EN
                err_d = (b_q == '0) | ovf_q;
`endif
                state_d = DONE;
            end

            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State register. Reset abandons any division in flight and clears the
    // visible results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            pr_q        <= '0;
            qm_q        <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
`ifdef SDIV_ERR_FLAG_EN
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pr_q        <= pr_d;
            qm_q        <= qm_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
`ifdef SDIV_ERR_FLAG_EN
            ovf_q       <= ovf_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
`ifdef SDIV_ERR_FLAG_EN
    assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_sdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_sdiv_seq
//
// Purpose: self-checking bench for sdiv_seq. Three instances (W=8, W=4,
// W=16) share one clock and reset. Expected results are pushed into a
// scoreboard queue when operands are driven and popped when a result shows
// up. The W=8 instance runs a fixed vector table plus backpressure and
// mid-operation reset sequences; W=4 is swept exhaustively and W=16 with
// random operands against a truncating reference model.
//
// Build option: define SDIV_ERR_FLAG_EN to also check the err output.
// ---------------------------------------------------------------------------
module tb_sdiv_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sdiv_seq_if #(.W(8))  if8  ();
    sdiv_seq_if #(.W(4))  if4  ();
    sdiv_seq_if #(.W(16)) if16 ();

    sdiv_seq #(.W(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
    sdiv_seq #(.W(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    sdiv_seq #(.W(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          e;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        bit         e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    // Width of the instance picked by sel.
    function automatic int widthOf(int sel);
        case (sel)
            1:       return 4;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    // Keep only the low w bits.
    function automatic logic [31:0] maskW(int w, logic [31:0] v);
        logic [31:0] m;
        m = (32'h1 << w) - 32'h1;
        return v & m;
    endfunction

    // Sign-extend the low w bits.
    function automatic longint sext(int w, logic [31:0] v);
        longint x;
        x = longint'(maskW(w, v));
        if (v[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Reference divider: truncating division from the simulator's own
    // arithmetic, with the defined divide-by-zero result.
    function automatic exp_t model(int sel, logic [31:0] a, logic [31:0] b);
        exp_t   x;
        int     w;
        longint sa, sbv, q, r;
        w   = widthOf(sel);
        sa  = sext(w, a);
        sbv = sext(w, b);
        if (sbv == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
        end
        x.sel = sel;
        x.a   = maskW(w, a);
        x.b   = maskW(w, b);
        x.q   = maskW(w, q[31:0]);
        x.r   = maskW(w, r[31:0]);
        x.e   = (sbv == 0) || ((sa == -(longint'(1) << (w - 1))) && (sbv == -1));
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic setInputs(int sel, logic v, logic [31:0] a, logic [31:0] b);
        case (sel)
            1: begin
                if4.in_valid = v; if4.dividend = a[3:0]; if4.divisor = b[3:0];
            end
            2: begin
                if16.in_valid = v; if16.dividend = a[15:0]; if16.divisor = b[15:0];
            end
            default: begin
                if8.in_valid = v; if8.dividend = a[7:0]; if8.divisor = b[7:0];
            end
        endcase
    endtask

    task automatic getOutputs(int sel, output logic ov, output logic ir,
                              output logic [31:0] q, output logic [31:0] r);
        case (sel)
            1: begin
                ov = if4.out_valid; ir = if4.in_ready;
                q = {28'b0, if4.quotient}; r = {28'b0, if4.remainder};
            end
            2: begin
                ov = if16.out_valid; ir = if16.in_ready;
                q = {16'b0, if16.quotient}; r = {16'b0, if16.remainder};
            end
            default: begin
                ov = if8.out_valid; ir = if8.in_ready;
                q = {24'b0, if8.quotient}; r = {24'b0, if8.remainder};
            end
        endcase
    endtask

`ifdef SDIV_ERR_FLAG_EN
    function automatic logic errOf(int sel);
        case (sel)
            1:       return if4.err;
            2:       return if16.err;
            default: return if8.err;
        endcase
    endfunction
`endif

    // Entered just after a falling edge with the instance idle: drive the
    // operands across one rising edge, record the expectation, then scramble
    // the operand lines since the divider must no longer depend on them.
    task automatic applyStimulus(int sel, logic [31:0] a, logic [31:0] b, exp_t x);
        sb.push_back(x);
        setInputs(sel, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        setInputs(sel, 1'b0, $urandom, $urandom);
    endtask

    // Counts rising edges from the accepting edge (inclusive) until out_valid
    // is seen, giving up after 64.
    task automatic waitValid(int sel, output int edges);
        logic        ov, ir;
        logic [31:0] q, r;
        edges = 1;
        getOutputs(sel, ov, ir, q, r);
        while (!ov && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            getOutputs(sel, ov, ir, q, r);
        end
    endtask

    // Waits for the result, compares it with the scoreboard head, checks the
    // algebraic invariants, then lets the output handshake complete.
    task automatic checkOutput(int sel, string name);
        int          edges, w;
        exp_t        x;
        logic        ov, ir;
        logic [31:0] q, r;
        longint      sq, sr, sa, sbv;
        bit          ok;
        w = widthOf(sel);
        waitValid(sel, edges);
        check({name, " latency"}, edges, w + 2);
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 0, 1);
            return;
        end
        x = sb.pop_front();
        getOutputs(sel, ov, ir, q, r);
        check({name, " quotient"}, q, x.q);
        check({name, " remainder"}, r, x.r);
`ifdef SDIV_ERR_FLAG_EN
        check({name, " err"}, {31'b0, errOf(sel)}, {31'b0, x.e});
`endif
        sbv = sext(w, x.b);
        if (sbv != 0) begin
            sq = sext(w, q);
            sr = sext(w, r);
            sa = sext(w, x.a);
            ok = (maskW(w, 32'(sq * sbv + sr)) == x.a) &&
                 ((sr < 0 ? -sr : sr) < (sbv < 0 ? -sbv : sbv)) &&
                 (sr == 0 || ((sr < 0) == (sa < 0)));
            check({name, " invariant"}, {31'b0, ok}, 32'h1);
        end
        @(posedge clk);
        @(negedge clk);
        getOutputs(sel, ov, ir, q, r);
        check({name, " out_valid drop"}, {31'b0, ov}, 32'h0);
        check({name, " in_ready back"}, {31'b0, ir}, 32'h1);
    endtask

    // Global time limit so a stuck design still ends the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, required test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t        x;
        logic        ov, ir;
        logic [31:0] q, r, a, b;
        int          edges;
        bit          saw_valid;

        vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
        vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0};
        vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0};
        vecs[3]  = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0};
        vecs[4]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b1};
        vecs[5]  = '{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1};
        vecs[6]  = '{8'd9,   8'd3,   8'h03, 8'h00, 1'b0};
        vecs[7]  = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0};
        vecs[8]  = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0};
        vecs[9]  = '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0};
        vecs[10] = '{8'hF9,  8'h00,  8'hFF, 8'hF9, 1'b1};
        vecs[11] = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0};
        vecs[12] = '{8'd3,   8'd7,   8'h00, 8'h03, 1'b0};
        vecs[13] = '{8'hFF,  8'h02,  8'h00, 8'hFF, 1'b0};
        vecs[14] = '{8'h7F,  8'h01,  8'h7F, 8'h00, 1'b0};
        vecs[15] = '{8'd7,   8'hFE,  8'hFD, 8'h01, 1'b0};

        if8.out_ready  = 1'b1;
        if4.out_ready  = 1'b1;
        if16.out_ready = 1'b1;
        setInputs(0, 1'b0, 32'h0, 32'h0);
        setInputs(1, 1'b0, 32'h0, 32'h0);
        setInputs(2, 1'b0, 32'h0, 32'h0);

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        getOutputs(0, ov, ir, q, r);
        check("reset out_valid", {31'b0, ov}, 32'h0);
        check("reset in_ready", {31'b0, ir}, 32'h1);
        check("reset quotient", q, 32'h0);
        check("reset remainder", r, 32'h0);
`ifdef SDIV_ERR_FLAG_EN
        check("reset err", {31'b0, if8.err}, 32'h0);
`endif
        rst = 1'b0;

        // Fixed W=8 vectors.
        for (int i = 0; i < 16; i++) begin
            x.sel = 0;
            x.a = {24'b0, vecs[i].a};
            x.b = {24'b0, vecs[i].b};
            x.q = {24'b0, vecs[i].q};
            x.r = {24'b0, vecs[i].r};
            x.e = vecs[i].e;
            applyStimulus(0, x.a, x.b, x);
            checkOutput(0, $sformatf("vec%0d", i));
        end

        // Backpressure: 77 / -5 = -15 rem 2, result held for five cycles
        // while new operands are offered and must be ignored.
        if8.out_ready = 1'b0;
        x = '{0, 32'd77, 32'hFB, 32'hF1, 32'h02, 1'b0};
        applyStimulus(0, 32'd77, 32'hFB, x);
        waitValid(0, edges);
        check("bp latency", edges, 10);
        x = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            setInputs(0, 1'b1, 32'd1, 32'd1);
            getOutputs(0, ov, ir, q, r);
            check($sformatf("bp%0d quotient", k), q, x.q);
            check($sformatf("bp%0d remainder", k), r, x.r);
            check($sformatf("bp%0d out_valid", k), {31'b0, ov}, 32'h1);
            check($sformatf("bp%0d in_ready", k), {31'b0, ir}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        setInputs(0, 1'b0, 32'd0, 32'd0);
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        getOutputs(0, ov, ir, q, r);
        check("bp release in_ready", {31'b0, ir}, 32'h1);
        check("bp release out_valid", {31'b0, ov}, 32'h0);
        check("bp held quotient", q, x.q);

        // Reset during the fourth CALC cycle: no result may appear.
        setInputs(0, 1'b1, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        setInputs(0, 1'b0, 32'd0, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        getOutputs(0, ov, ir, q, r);
        check("abort out_valid", {31'b0, ov}, 32'h0);
        check("abort in_ready", {31'b0, ir}, 32'h1);
        check("abort quotient", q, 32'h0);
        check("abort remainder", r, 32'h0);
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (if8.out_valid) saw_valid = 1'b1;
        end
        check("abort no result", {31'b0, saw_valid}, 32'h0);
        x = '{0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
        applyStimulus(0, 32'd9, 32'd3, x);
        checkOutput(0, "after abort 9/3");

        // W=4 exhaustive sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a = 32'(ia);
                b = 32'(ib);
                applyStimulus(1, a, b, model(1, a, b));
                checkOutput(1, $sformatf("w4 %0d/%0d", ia, ib));
            end
        end

        // W=16 random sweep with forced corner operands.
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(0, 16)) - 32'd8;
            if (i == 0) begin a = 32'h8000; b = 32'hFFFF; end
            if (i == 2) begin a = 32'h8000; b = 32'h0000; end
            if (i == 3) begin a = 32'h7FFF; b = 32'h8000; end
            applyStimulus(2, a, b, model(2, a, b));
            checkOutput(2, $sformatf("w16 #%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
